usb_protocol_ctrl: RTL and testbench



---
 rtl/usb_protocol_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_usb_protocol_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_protocol_ctrl.sv
// usb_protocol_ctrl: bulk-endpoint protocol sequencer between the USB RX
// decoder, the USB TX encoder and the AHB-Lite buffer owner.
// Optional feature macro: USB_PROTO_TOGGLE_CHECK_EN enables DATA0/DATA1
// toggle tracking. When it is undefined, every DATA packet is new data and
// IN transactions always send DATA0.
module usb_protocol_ctrl #(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_packet_valid,
  input  logic [2:0] rx_packet,
  input  logic       rx_data_done,
  input  logic       rx_decode_error,
  input  logic       tx_done,
  input  logic [6:0] buffer_occupancy,
  input  logic [6:0] tx_packet_data_size,
  input  logic       buffer_reserved,
  output logic       tx_start,
  output logic [1:0] tx_pid,
  output logic       clear,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       tx_transfer_active,
  output logic       rx_error,
  output logic       tx_error,
  output logic       d_mode
);

  localparam logic [2:0] PID_OUT   = 3'd1;
  localparam logic [2:0] PID_IN    = 3'd2;
  localparam logic [2:0] PID_DATA0 = 3'd3;
  localparam logic [2:0] PID_DATA1 = 3'd4;
  localparam logic [2:0] PID_ACK   = 3'd5;
  localparam logic [2:0] PID_NAK   = 3'd6;

  localparam logic [1:0] TXP_DATA0 = 2'd0;
  localparam logic [1:0] TXP_DATA1 = 2'd1;
  localparam logic [1:0] TXP_ACK   = 2'd2;
  localparam logic [1:0] TXP_NAK   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_WAIT_DATA,
    S_SEND_ACK,
    S_SEND_NAK,
    S_TX_SEND_DATA,
    S_TX_WAIT_ACK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             pid_seen, pid_new;
  logic             pid_fresh;
  logic [1:0]       data_pid;

  logic             act_tx_start, act_clear, set_ready, ack_taken;
  logic             rx_err_set, rx_err_clr, tx_err_set, tx_err_clr;
  logic [1:0]       tx_pid_nxt;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // A decode error in the same cycle masks the PID strobe and data-done strobe.
  logic pkt_ok, is_token, is_data, is_hs, data_done_ok, in_wait, timeout;
  logic in_ready, out_ready;

  assign pkt_ok       = rx_packet_valid && !rx_decode_error;
  assign is_token     = pkt_ok && (rx_packet == PID_OUT || rx_packet == PID_IN);
  assign is_data      = pkt_ok && (rx_packet == PID_DATA0 || rx_packet == PID_DATA1);
  assign is_hs        = pkt_ok && (rx_packet == PID_ACK || rx_packet == PID_NAK);
  assign data_done_ok = rx_data_done && !rx_decode_error;
  assign in_wait      = (state == S_RX_WAIT_DATA) || (state == S_TX_WAIT_ACK);
  assign timeout      = in_wait && (cnt == CNT_LAST);
  assign in_ready     = (tx_packet_data_size != 7'd0) &&
                        (buffer_occupancy >= tx_packet_data_size);
  assign out_ready    = (buffer_occupancy == 7'd0) && !buffer_reserved;

`ifdef USB_PROTO_TOGGLE_CHECK_EN
  logic rx_toggle, tx_toggle;

  assign pid_fresh = ((rx_packet == PID_DATA1) == rx_toggle);
  assign data_pid  = tx_toggle ? TXP_DATA1 : TXP_DATA0;

  // Toggle registers advance on accepted new OUT data and on ACKed IN data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_toggle <= 1'b0;
      tx_toggle <= 1'b0;
    end else begin
      if (set_ready) rx_toggle <= ~rx_toggle;
      if (ack_taken) tx_toggle <= ~tx_toggle;
    end
  end
`else
  assign pid_fresh = 1'b1;
  assign data_pid  = TXP_DATA0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (is_token) begin
          if (rx_packet == PID_OUT) state_nxt = out_ready ? S_RX_WAIT_DATA : S_SEND_NAK;
          else                      state_nxt = in_ready  ? S_TX_SEND_DATA : S_SEND_NAK;
        end
      end
      S_RX_WAIT_DATA: begin
        if (rx_decode_error || is_token || is_hs) state_nxt = S_IDLE;
        else if (data_done_ok && pid_seen)        state_nxt = S_SEND_ACK;
        else if (timeout)                         state_nxt = S_IDLE;
      end
      S_SEND_ACK, S_SEND_NAK: begin
        if (tx_done) state_nxt = S_IDLE;
      end
      S_TX_SEND_DATA: begin
        if (tx_done) state_nxt = S_TX_WAIT_ACK;
      end
      S_TX_WAIT_ACK: begin
        if (rx_decode_error || is_hs || timeout) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output actions derived from the transition being taken this cycle.
  always_comb begin
    act_tx_start = (state_nxt != state) &&
                   (state_nxt == S_SEND_ACK || state_nxt == S_SEND_NAK ||
                    state_nxt == S_TX_SEND_DATA);
    case (state_nxt)
      S_SEND_ACK: tx_pid_nxt = TXP_ACK;
      S_SEND_NAK: tx_pid_nxt = TXP_NAK;
      default:    tx_pid_nxt = data_pid;
    endcase
    set_ready  = (state == S_RX_WAIT_DATA) && (state_nxt == S_SEND_ACK) && pid_new;
    ack_taken  = (state == S_TX_WAIT_ACK) && is_hs && (rx_packet == PID_ACK);
    rx_err_clr = (state == S_IDLE) && (state_nxt == S_RX_WAIT_DATA);
    rx_err_set = (state == S_RX_WAIT_DATA) && (state_nxt == S_IDLE);
    tx_err_clr = (state == S_IDLE) && (state_nxt == S_TX_SEND_DATA);
    tx_err_set = (state == S_TX_WAIT_ACK) && (state_nxt == S_IDLE) && !ack_taken;
    act_clear  = rx_err_clr || rx_err_set ||
                 ((state == S_RX_WAIT_DATA) && (state_nxt == S_SEND_ACK) && !pid_new) ||
                 ((state == S_TX_WAIT_ACK) && (state_nxt == S_IDLE));
  end

  // Timeout counter: zeroed on every state change, counts while waiting.
  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (in_wait)            cnt <= sat_inc(cnt);
  end

  // Remember which DATA PID opened the current OUT data phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      pid_seen <= 1'b0;
      pid_new  <= 1'b0;
    end else if (state != S_RX_WAIT_DATA) begin
      pid_seen <= 1'b0;
    end else if (is_data) begin
      pid_seen <= 1'b1;
      pid_new  <= pid_fresh;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start           <= 1'b0;
      tx_pid             <= TXP_DATA0;
      clear              <= 1'b0;
      rx_data_ready      <= 1'b0;
      rx_transfer_active <= 1'b0;
      tx_transfer_active <= 1'b0;
      rx_error           <= 1'b0;
      tx_error           <= 1'b0;
      d_mode             <= 1'b0;
    end else begin
      tx_start <= act_tx_start;
      if (act_tx_start) tx_pid <= tx_pid_nxt;
      clear <= act_clear;
      if (set_ready)
        rx_data_ready <= 1'b1;
      else if (act_clear || (state == S_IDLE && buffer_occupancy == 7'd0))
        rx_data_ready <= 1'b0;
      rx_transfer_active <= (state_nxt == S_RX_WAIT_DATA);
      tx_transfer_active <= (state_nxt == S_TX_SEND_DATA) || (state_nxt == S_TX_WAIT_ACK);
      if (rx_err_set)      rx_error <= 1'b1;
      else if (rx_err_clr) rx_error <= 1'b0;
      if (tx_err_set)      tx_error <= 1'b1;
      else if (tx_err_clr) tx_error <= 1'b0;
      d_mode <= (state_nxt == S_SEND_ACK) || (state_nxt == S_SEND_NAK) ||
                (state_nxt == S_TX_SEND_DATA);
    end
  end

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Directed testbench for usb_protocol_ctrl. Expected values follow both
// builds: USB_PROTO_TOGGLE_CHECK_EN defined (toggle tracking) or undefined.
module tb_usb_protocol_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_packet_valid = 1'b0;
  logic [2:0] rx_packet = 3'd0;
  logic       rx_data_done = 1'b0;
  logic       rx_decode_error = 1'b0;
  logic       tx_done = 1'b0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic [6:0] tx_packet_data_size = 7'd0;
  logic       buffer_reserved = 1'b0;
  logic       tx_start;
  logic [1:0] tx_pid;
  logic       clear;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       tx_transfer_active;
  logic       rx_error;
  logic       tx_error;
  logic       d_mode;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef USB_PROTO_TOGGLE_CHECK_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  usb_protocol_ctrl #(.TIMEOUT_CYCLES(200), .CNT_W(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_packet_valid     (rx_packet_valid),
    .rx_packet           (rx_packet),
    .rx_data_done        (rx_data_done),
    .rx_decode_error     (rx_decode_error),
    .tx_done             (tx_done),
    .buffer_occupancy    (buffer_occupancy),
    .tx_packet_data_size (tx_packet_data_size),
    .buffer_reserved     (buffer_reserved),
    .tx_start            (tx_start),
    .tx_pid              (tx_pid),
    .clear               (clear),
    .rx_data_ready       (rx_data_ready),
    .rx_transfer_active  (rx_transfer_active),
    .tx_transfer_active  (tx_transfer_active),
    .rx_error            (rx_error),
    .tx_error            (tx_error),
    .d_mode              (d_mode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pkt(input logic [2:0] pid);
    rx_packet_valid = 1'b1;
    rx_packet       = pid;
    step();
    rx_packet_valid = 1'b0;
    rx_packet       = 3'd0;
  endtask

  task automatic data_done();
    rx_data_done = 1'b1;
    step();
    rx_data_done = 1'b0;
  endtask

  task automatic txd();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check("rst_tx_start", tx_start, 0);
    check("rst_clear", clear, 0);
    check("rst_dmode", d_mode, 0);
    check("rst_rx_act", rx_transfer_active, 0);
    check("rst_errs", {rx_error, tx_error, rx_data_ready}, 0);
    rst = 1'b0;
    step();

    // OUT into empty buffer, DATA0 accepted
    pkt(3'd1);
    check("out_clear", clear, 1);
    check("out_rx_act", rx_transfer_active, 1);
    check("out_no_start", tx_start, 0);
    step();
    check("out_clear_1cyc", clear, 0);
    pkt(3'd3);
    check("data0_wait", rx_transfer_active, 1);
    data_done();
    check("ack_start", tx_start, 1);
    check("ack_pid", tx_pid, 2);
    check("ack_dmode", d_mode, 1);
    check("ack_ready", rx_data_ready, 1);
    check("ack_no_clear", clear, 0);
    check("ack_rx_act", rx_transfer_active, 0);
    buffer_occupancy = 7'd8;
    step();
    check("ack_start_1cyc", tx_start, 0);
    check("ack_dmode_hold", d_mode, 1);
    txd();
    check("ack_dmode_fall", d_mode, 0);
    check("ready_held", rx_data_ready, 1);
    buffer_occupancy = 7'd0;
    step();
    check("ready_drained", rx_data_ready, 0);

    // Repeat OUT/DATA0: duplicate when toggles are tracked
    pkt(3'd1);
    check("dup_out_clear", clear, 1);
    pkt(3'd3);
    data_done();
    check("dup_ack_start", tx_start, 1);
    check("dup_ack_pid", tx_pid, 2);
    check("dup_clear", clear, TOG ? 1 : 0);
    check("dup_ready", rx_data_ready, TOG ? 0 : 1);
    txd();
    step();
    check("dup_ready_end", rx_data_ready, 0);

    // OUT/DATA1 is new data in both builds
    pkt(3'd1);
    pkt(3'd4);
    data_done();
    check("d1_pid", tx_pid, 2);
    check("d1_ready", rx_data_ready, 1);
    check("d1_clear", clear, 0);
    txd();
    step();

    // IN with 8 committed bytes and 8 held
    buffer_occupancy    = 7'd8;
    tx_packet_data_size = 7'd8;
    pkt(3'd2);
    check("in1_start", tx_start, 1);
    check("in1_pid", tx_pid, 0);
    check("in1_dmode", d_mode, 1);
    check("in1_tx_act", tx_transfer_active, 1);
    check("in1_no_clear", clear, 0);
    step();
    check("in1_start_1cyc", tx_start, 0);
    txd();
    check("in1_dmode_fall", d_mode, 0);
    check("in1_wait_act", tx_transfer_active, 1);
    pkt(3'd5);
    check("in1_ack_clear", clear, 1);
    check("in1_ack_act", tx_transfer_active, 0);
    check("in1_ack_err", tx_error, 0);

    // Second IN follows the tx toggle; NAK sets tx_error
    pkt(3'd2);
    check("in2_pid", tx_pid, TOG ? 1 : 0);
    txd();
    pkt(3'd6);
    check("in2_nak_err", tx_error, 1);
    check("in2_nak_clear", clear, 1);
    pkt(3'd2);
    check("in3_err_clr", tx_error, 0);
    check("in3_pid", tx_pid, TOG ? 1 : 0);
    txd();
    pkt(3'd5);
    step();

    // IN with too few bytes, OUT into non-empty buffer: both NAKed
    buffer_occupancy = 7'd4;
    pkt(3'd2);
    check("in_nak_start", tx_start, 1);
    check("in_nak_pid", tx_pid, 3);
    check("in_nak_no_clear", clear, 0);
    check("in_nak_tx_act", tx_transfer_active, 0);
    txd();
    check("in_nak_dmode", d_mode, 0);
    pkt(3'd1);
    check("out_nak_pid", tx_pid, 3);
    check("out_nak_no_clear", clear, 0);
    check("out_nak_rx_act", rx_transfer_active, 0);
    txd();

    // OUT then silence: timeout after 200 cycles
    buffer_occupancy = 7'd0;
    pkt(3'd1);
    repeat (199) step();
    check("to_before_err", rx_error, 0);
    check("to_before_act", rx_transfer_active, 1);
    step();
    check("to_err", rx_error, 1);
    check("to_clear", clear, 1);
    check("to_no_start", tx_start, 0);
    check("to_idle", rx_transfer_active, 0);
    pkt(3'd1);
    check("to_err_cleared", rx_error, 0);
    check("to_next_clear", clear, 1);

    // Decode error beats simultaneous DATA PID and data-done
    rx_packet_valid = 1'b1;
    rx_packet       = 3'd3;
    rx_data_done    = 1'b1;
    rx_decode_error = 1'b1;
    step();
    rx_packet_valid = 1'b0;
    rx_packet       = 3'd0;
    rx_data_done    = 1'b0;
    rx_decode_error = 1'b0;
    check("derr_err", rx_error, 1);
    check("derr_clear", clear, 1);
    check("derr_no_start", tx_start, 0);
    check("derr_idle", rx_transfer_active, 0);

    // Reset during TX_WAIT_ACK with the tx toggle advanced
    buffer_occupancy = 7'd8;
    pkt(3'd2);
    txd();
    pkt(3'd5);
    pkt(3'd2);
    check("pre_rst_pid", tx_pid, TOG ? 1 : 0);
    txd();
    check("pre_rst_wait", tx_transfer_active, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_tx_act", tx_transfer_active, 0);
    check("mid_rst_clear", clear, 0);
    check("mid_rst_rx_error", rx_error, 0);
    check("mid_rst_outs", {tx_start, tx_pid, rx_data_ready, rx_transfer_active, tx_error, d_mode}, 0);
    pkt(3'd2);
    check("post_rst_start", tx_start, 1);
    check("post_rst_pid", tx_pid, 0);
    txd();
    pkt(3'd5);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
